// File: rtl/decode_queue_if.sv
// Handshake and decoded-head bundle for decode_queue.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface decode_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] inst;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic       type_1;
  logic       type_2;
  logic       type_3;
  logic       type_4;
  logic       type_5;
  logic [1:0] r1;
  logic [1:0] r2;
  logic [3:0] funct;
  logic [5:0] immediate;

  modport master (
    output in_valid, inst, flush, out_ready,
    input  in_ready, out_valid, type_1, type_2, type_3, type_4, type_5,
           r1, r2, funct, immediate
  );

  modport slave (
    input  in_valid, inst, flush, out_ready,
    output in_ready, out_valid, type_1, type_2, type_3, type_4, type_5,
           r1, r2, funct, immediate
  );
endinterface

// File: rtl/decode_queue.sv
// Instruction decode followed by a DEPTH-entry FIFO of decoded entries.
// Optional pop counter perf_cnt is built only when DECODE_PERF_EN is defined.
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  decode_queue_if.slave q
`ifdef DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH != 2 && DEPTH != 4 && DEPTH != 8) || CNT_W < 1) begin : g_bad_params
    $error("decode_queue: DEPTH must be 2, 4 or 8 and CNT_W at least 1");
  end

  // typ[0] is type_1 ... typ[4] is type_5
  typedef struct packed {
    logic [4:0] typ;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [3:0] funct;
    logic [5:0] imm;
  } entry_t;

  function automatic entry_t decode(input logic [8:0] w);
    entry_t e;
    e = '0;
    if (w[8:6] == 3'b111) begin
      e.typ = 5'b01000;
      e.imm = w[5:0];
    end else if (w[8]) begin
      e.typ   = 5'b00010;
      e.funct = {2'b00, w[7:6]};
      e.r1    = w[5:4];
      e.imm   = {2'b00, w[3:0]};
    end else if (w[8:6] == 3'b011) begin
      e.typ   = 5'b00010;
      e.funct = {3'b100, w[5]};
      e.r1    = w[4:3];
      e.imm   = {3'b000, w[2:0]};
    end else if (w[8:4] == 5'b01011) begin
      e.typ = 5'b01000;
      e.imm = {2'b00, w[3:0]};
    end else if (w[8:4] != 5'b0) begin
      e.typ   = 5'b00001;
      e.funct = w[7:4];
      e.r1    = w[3:2];
      e.r2    = w[1:0];
    end else if (w[8:2] != 7'b0) begin
      e.typ   = 5'b00100;
      e.funct = {2'b00, w[3:2]};
      e.r1    = w[1:0];
    end else begin
      e.typ   = 5'b10000;
      e.funct = {3'b000, w[0]};
    end
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full, empty, push, pop;
  entry_t          head;

  // Ready and valid come only from the occupancy register, never from inputs.
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = q.in_valid && !full;
  assign pop   = q.out_ready && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (q.flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: it is only visible while occupancy is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= decode(q.inst);
  end

  assign head = empty ? '0 : mem_q[rd_q];

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.type_1    = head.typ[0];
  assign q.type_2    = head.typ[1];
  assign q.type_3    = head.typ[2];
  assign q.type_4    = head.typ[3];
  assign q.type_5    = head.typ[4];
  assign q.r1        = head.r1;
  assign q.r2        = head.r2;
  assign q.funct     = head.funct;
  assign q.immediate = head.imm;

`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] perf_q;

  // A pop in a flushing cycle is discarded, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  perf_q <= '0;
    else if (pop && !q.flush) perf_q <= perf_q + CNT_W'(1);
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Randomized and directed bench for decode_queue against a queue-based reference model.
// Build with DECODE_PERF_EN defined to also check the pop counter.
module tb_decode_queue;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  decode_queue_if qif ();
`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] perf_cnt;
`endif

  decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
`ifdef DECODE_PERF_EN
    ,
    .perf_cnt (perf_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [8:0] exp_q[$];
  int         ref_perf;
  int         n_checks;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: {type_5..type_1, r1, r2, funct, immediate}
  function automatic logic [18:0] ref_dec(input logic [8:0] w);
    logic [4:0] t;
    logic [1:0] a, b;
    logic [3:0] fn;
    logic [5:0] im;
    t = 0; a = 0; b = 0; fn = 0; im = 0;
    casez (w)
      9'b111??????: begin t = 5'b01000; im = w[5:0]; end
      9'b1????????: begin t = 5'b00010; fn = {2'b0, w[7:6]}; a = w[5:4]; im = {2'b0, w[3:0]}; end
      9'b011??????: begin t = 5'b00010; fn = {3'b100, w[5]}; a = w[4:3]; im = {3'b0, w[2:0]}; end
      9'b01011????: begin t = 5'b01000; im = {2'b0, w[3:0]}; end
      default: begin
        if (w[8:4] != 0)      begin t = 5'b00001; fn = w[7:4]; a = w[3:2]; b = w[1:0]; end
        else if (w[8:2] != 0) begin t = 5'b00100; fn = {2'b0, w[3:2]}; a = w[1:0]; end
        else                  begin t = 5'b10000; fn = {3'b0, w[0]}; end
      end
    endcase
    return {t, a, b, fn, im};
  endfunction

  function automatic logic [18:0] dut_head();
    return {qif.type_5, qif.type_4, qif.type_3, qif.type_2, qif.type_1,
            qif.r1, qif.r2, qif.funct, qif.immediate};
  endfunction

  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check("in_ready", 32'(qif.in_ready), 32'(sz < DEPTH));
    check("out_valid", 32'(qif.out_valid), 32'(sz > 0));
    check("head", 32'(dut_head()), (sz > 0) ? 32'(ref_dec(exp_q[0])) : 32'd0);
`ifdef DECODE_PERF_EN
    check("perf_cnt", 32'(perf_cnt), 32'(ref_perf % (1 << CNT_W)));
`endif
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic cycle(input logic iv, input logic [8:0] w, input logic ordy, input logic fl);
    bit do_push, do_pop;
    qif.in_valid  = iv;
    qif.inst      = w;
    qif.out_ready = ordy;
    qif.flush     = fl;
    check_state();
    do_push = iv && (exp_q.size() < DEPTH);
    do_pop  = ordy && (exp_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        ref_perf++;
      end
      if (do_push) exp_q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    ref_perf = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int drained;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    qif.in_valid  = 1'b0;
    qif.inst      = '0;
    qif.out_ready = 1'b0;
    qif.flush     = 1'b0;
    do_reset();
    check_state();

    // single type_4 entry, 1-cycle latency
    cycle(1'b1, 9'b111101010, 1'b1, 1'b0);
    check("lat_valid", 32'(qif.out_valid), 32'd1);
    check("lat_type4", 32'(qif.type_4), 32'd1);
    check("lat_imm", 32'(qif.immediate), 32'h2a);
    check("lat_funct", 32'(qif.funct), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // ordered stream of three entries
    cycle(1'b1, 9'b1_10_01_0111, 1'b0, 1'b0);
    check("ord1", 32'(dut_head()), 32'({5'b00010, 2'b01, 2'b00, 4'b0010, 6'b000111}));
    cycle(1'b1, 9'b011_1_10_101, 1'b1, 1'b0);
    check("ord2", 32'(dut_head()), 32'({5'b00010, 2'b10, 2'b00, 4'b1001, 6'b000101}));
    cycle(1'b1, 9'b0_0000_0001, 1'b1, 1'b0);
    check("ord3", 32'(dut_head()), 32'({5'b10000, 2'b00, 2'b00, 4'b0001, 6'b000000}));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // overflow: third push while full is dropped
    cycle(1'b1, 9'h0a5, 1'b0, 1'b0);
    cycle(1'b1, 9'h1c3, 1'b0, 1'b0);
    check("full_ready", 32'(qif.in_ready), 32'd0);
    cycle(1'b1, 9'h033, 1'b0, 1'b0);
    drained = 0;
    for (int i = 0; i < 8 && qif.out_valid; i++) begin
      drained++;
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_cnt", 32'(drained), 32'd2);

    // flush overrides simultaneous push and pop
    cycle(1'b1, 9'h045, 1'b0, 1'b0);
    cycle(1'b1, 9'h146, 1'b0, 1'b0);
    cycle(1'b1, 9'h0ff, 1'b1, 1'b1);
    check("flush_valid", 32'(qif.out_valid), 32'd0);
    check("flush_ready", 32'(qif.in_ready), 32'd1);

    // asynchronous reset between edges
    cycle(1'b1, 9'h1f0, 1'b0, 1'b0);
    qif.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    ref_perf = 0;
    check("arst_valid", 32'(qif.out_valid), 32'd0);
    check("arst_ready", 32'(qif.in_ready), 32'd1);
    check("arst_head", 32'(dut_head()), 32'd0);
`ifdef DECODE_PERF_EN
    check("arst_perf", 32'(perf_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 9'h02c, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 17 pops wrap a 4-bit counter to 1
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1'b1, 9'($urandom_range(0, 511)), 1'b1, 1'b0);
`ifdef DECODE_PERF_EN
    check("perf_wrap", 32'(perf_cnt), 32'd1);
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of decoded-instruction entries buffered; legal values 2, 4, 8.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the performance counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  inst is presented.
REQ-006 in_ready  output  1  entry will be accepted this cycle; equals not-full, with no combinational path from any input.
REQ-007 inst  input  9  raw instruction word.
REQ-008 flush  input  1  discard all buffered entries.
REQ-009 out_valid  output  1  head entry is valid.
REQ-010 out_ready  input  1  consumer takes the head entry.
REQ-011 type_1..type_5  output  1 each  one-hot format of the head entry: two regs / reg+imm / reg / imm / none.
REQ-012 r1, r2  output  2 each  register fields of the head entry.
REQ-013 funct  output  4  function code of the head entry.
REQ-014 immediate  output  6  zero-extended immediate of the head entry.
REQ-015 perf_cnt  output  CNT_W  count of entries popped; present only with DECODE_PERF_EN.

Function
REQ-016 Decode SHALL use first match in this order; unused fields are 0:
- inst[8:6]=111 -> type_4; immediate=inst[5:0].
- inst[8]=1 -> type_2; funct={00,inst[7:6]}; r1=inst[5:4]; immediate={00,inst[3:0]}.
- inst[8:6]=011 -> type_2; funct={100,inst[5]}; r1=inst[4:3]; immediate={000,inst[2:0]}.
- inst[8:4]=01011 -> type_4; immediate={00,inst[3:0]}.
- inst[8:4]!=0 -> type_1; funct=inst[7:4]; r1=inst[3:2]; r2=inst[1:0].
- inst[8:2]!=0 -> type_3; funct={00,inst[3:2]}; r1=inst[1:0].
- otherwise -> type_5; funct={000,inst[0]}.
REQ-017 Exactly one type_* SHALL be 1 whenever out_valid=1; all decoded outputs SHALL be 0 whenever out_valid=0.
REQ-018 Push occurs on an edge with in_valid&&in_ready; pop occurs on an edge with out_valid&&out_ready.
REQ-019 Decode SHALL be performed before storage, so an entry pushed at edge N is visible on the outputs from edge N+1 when the queue was empty (1-cycle latency).
REQ-020 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; this is legal when full only if in_ready was 1, i.e. never. A full queue accepts nothing even while popping.
REQ-022 Pop when empty and push when full SHALL have no effect.
REQ-023 flush SHALL empty the queue at the next edge, overriding any simultaneous push and pop; the flushing cycle's pop SHALL NOT count in perf_cnt.

Reset
REQ-024 rst SHALL immediately clear pointers and occupancy, drive out_valid=0, in_ready=1, all decoded outputs to 0, and perf_cnt to 0.
REQ-025 rst asserted mid-operation SHALL discard all entries; the first push after release behaves as on an empty queue.

Configuration
REQ-026 With macro DECODE_PERF_EN defined, perf_cnt SHALL increment by 1 per pop, wrap from all-ones to 0, and be unaffected by flush.
REQ-027 Without DECODE_PERF_EN, the perf_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Push inst=9'b111101010 on an empty queue, out_ready=1 -> next cycle out_valid=1, type_4=1, immediate=6'b101010, funct=0.
REQ-029 Push 9'b1_10_01_0111, then 9'b011_1_10_101, then 9'b0_0000_0001 -> popped in order as type_2 funct=0010 r1=01 imm=000111; type_2 funct=1001 r1=10 imm=000101; type_5 funct=0001.
REQ-030 DEPTH=2, out_ready=0, push 3 times -> in_ready=0 after 2nd push; 3rd entry not stored; draining yields exactly 2 entries.
REQ-031 Queue holds 2 entries, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, perf_cnt unchanged.
REQ-032 Assert rst asynchronously between edges with 1 entry held -> out_valid falls before the next edge; perf_cnt=0.
REQ-033 DECODE_PERF_EN with CNT_W=4: 17 pops -> perf_cnt=1.
